// File: rtl/post_proc_sequencer.sv
// Frame sequencer for the post-processing reduction pipeline: gates conv vectors into the
// fixed-latency pipeline and buffers its results in a credit-protected output FIFO.
module post_proc_sequencer #(
  parameter int FEATURE_WIDTH = 16,
  parameter int OUT_ROWS      = 24,
  parameter int OUT_COLS      = 24,
  parameter int PP_LATENCY    = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     frame_done,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     pp_features_valid,
  input  logic [FEATURE_WIDTH-1:0] pp_feature_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FEATURE_WIDTH-1:0] out_data,
  output logic                     out_last,
  output logic [1:0]               dbg_state
);

  localparam int TOTAL = OUT_ROWS * OUT_COLS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW    = $clog2(FIFO_DEPTH + 1);
  localparam int IW    = $clog2(PP_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            acc_cnt_q, acc_cnt_d;
  logic [PP_LATENCY-1:0]    vsr_q, vsr_d;
  logic [PP_LATENCY-1:0]    lsr_q, lsr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]            cnt_q, cnt_d;
  logic [FEATURE_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic                     mem_last_q [FIFO_DEPTH];

  logic [IW-1:0] inflight;
  logic          credit_ok;
  logic          accept;
  logic          last_tag;
  logic          push;
  logic          pop;
  logic          start_frame;

  // Handshakes: a transfer happens on a clk edge where valid && ready are both high. in_ready
  // never looks at in_valid; out_valid never looks at out_ready.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PP_LATENCY; i++) begin
      inflight = inflight + IW'(vsr_q[i]);
    end
  end

  // Every accepted vector is already owed a FIFO slot, so the un-stallable pipeline can never overrun.
  assign credit_ok = (32'(cnt_q) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign in_ready  = (state_q == S_RUN) && credit_ok && (acc_cnt_q < CW'(TOTAL));
  assign accept    = in_valid && in_ready;
  assign pp_features_valid = accept;

  assign last_tag    = accept && (acc_cnt_q == CW'(TOTAL - 1));
  assign push        = vsr_q[PP_LATENCY-1];
  assign pop         = out_valid && out_ready;
  assign start_frame = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (acc_cnt_q == CW'(TOTAL)) state_d = S_DRAIN;
      S_DRAIN: if ((vsr_q == '0) && (cnt_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (start_frame) begin
      acc_cnt_d = '0;
    end else if (accept) begin
      acc_cnt_d = acc_cnt_q + CW'(1);
    end
  end

  // Validity and the last-feature tag ride alongside the pipeline's own stages.
  assign vsr_d = (vsr_q << 1) | PP_LATENCY'(accept);
  assign lsr_d = (lsr_q << 1) | PP_LATENCY'(last_tag);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + NW'(1);
      2'b01:   cnt_d = cnt_q - NW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_cnt_q <= '0;
      vsr_q     <= '0;
      lsr_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      vsr_q     <= vsr_d;
      lsr_q     <= lsr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= pp_feature_out;
      mem_last_q[wr_ptr_q] <= lsr_q[PP_LATENCY-1];
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign out_data   = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_last   = out_valid && mem_last_q[rd_ptr_q];
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign frame_done = (state_q == S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_post_proc_sequencer.sv
// Directed bench for post_proc_sequencer with a 4-stage reduction pipeline stub and an
// expected-value queue fed at accept time.
module tb_post_proc_sequencer;

  localparam int FW    = 16;
  localparam int TOTAL = 576;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, frame_done, in_ready, pp_features_valid, out_valid, out_last;
  logic [FW-1:0] pp_feature_out, out_data;
  logic [1:0]    dbg_state;

  logic [FW-1:0] feat [4];
  logic [FW-1:0] s1a, s1b, s2, s3, s4;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [FW-1:0] exp_q[$];
  logic [LAT-1:0] acc_hist = '0;
  int            occ = 0, max_occ = 0;
  int            acc_total, pops, last_cnt, last_idx, done_cnt, pfv_bad;
  int            first_acc_cyc, last_acc_cyc, first_ov_cyc, last_pop_cyc, done_cyc;
  int            start_cyc, ov_seen;
  logic [FW-1:0] first_data;

  // ---------------- clock / DUT / pipeline stub ----------------
  always #5 clk = ~clk;

  post_proc_sequencer #(
    .FEATURE_WIDTH(FW), .OUT_ROWS(24), .OUT_COLS(24), .PP_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .in_valid(in_valid), .in_ready(in_ready), .pp_features_valid(pp_features_valid),
    .pp_feature_out(pp_feature_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .dbg_state(dbg_state)
  );

  // Reduction pipeline: (f0+f1) - (f2-f3), output valid 4 edges after the sampling edge.
  always @(posedge clk) begin
    s1a <= feat[0] + feat[1];
    s1b <= feat[2] - feat[3];
    s2  <= s1a - s1b;
    s3  <= s2;
    s4  <= s3;
  end
  assign pp_feature_out = s4;

  // ---------------- helpers ----------------
  function automatic logic [FW-1:0] golden(input logic [FW-1:0] a, b, c, d);
    logic [FW-1:0] x, y;
    x = a + b;
    y = c - d;
    return x - y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    acc_total = 0; pops = 0; last_cnt = 0; last_idx = 0; done_cnt = 0; pfv_bad = 0;
    first_acc_cyc = -1; last_acc_cyc = -1; first_ov_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    first_data = '0;
  endtask

  // Scoreboard sampling on the falling edge, between driver updates.
  task automatic monitor();
    logic acc, pop, pushed;
    logic [FW-1:0] e;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pp_features_valid !== acc) pfv_bad++;
    if (!rst_n) begin
      acc_hist = '0;
      occ = 0;
    end else begin
      if (pop) begin
        pops++;
        if (pops == 1) first_data = out_data;
        if (exp_q.size() == 0) begin
          check("pop_without_expected", 32'(pops), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
        end
        if (out_last) begin
          last_cnt++;
          last_idx = pops;
        end
        last_pop_cyc = cyc;
      end
      if (acc) begin
        exp_q.push_back(golden(feat[0], feat[1], feat[2], feat[3]));
        acc_total++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
      end
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      pushed = acc_hist[LAT-1];
      occ = occ + int'(pushed) - int'(pop);
      if (occ > max_occ) max_occ = occ;
      acc_hist = {acc_hist[LAT-2:0], acc};
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_feat(input bit ones);
    for (int i = 0; i < 4; i++) feat[i] = ones ? FW'(1) : FW'($urandom());
  endtask

  task automatic pulse_start(input bit ones);
    start_cyc = cyc;
    start = 1'b1;
    in_valid = 1'b1;
    drive_feat(ones);
    tick();
    start = 1'b0;
  endtask

  task automatic finish_frame(input int in_pct, input int out_pct, input bit ones, input bit abuse);
    for (int n = 0; n < 20000 && done_cnt == 0; n++) begin
      in_valid  = ($urandom_range(0, 99) < in_pct);
      out_ready = ($urandom_range(0, 99) < out_pct);
      drive_feat(ones);
      start = abuse && busy && ($urandom_range(0, 9) == 0);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_frame_done_count"}, 32'(done_cnt), 32'(1));
    check({tag, "_accepts"}, 32'(acc_total), 32'(TOTAL));
    check({tag, "_pops"}, 32'(pops), 32'(TOTAL));
    check({tag, "_last_count"}, 32'(last_cnt), 32'(1));
    check({tag, "_last_index"}, 32'(last_idx), 32'(TOTAL));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_done_after_empty"}, 32'(done_cyc - last_pop_cyc), 32'(2));
    check({tag, "_pp_valid_mismatch"}, 32'(pfv_bad), 32'(0));
    check({tag, "_idle_state"}, 32'(dbg_state), 32'(0));
    check({tag, "_busy_low"}, 32'(busy), 32'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive_feat(1'b0);
    clear_stats();
    repeat (3) tick();
    check("por_busy", 32'(busy), 32'(0));
    check("por_frame_done", 32'(frame_done), 32'(0));
    check("por_in_ready", 32'(in_ready), 32'(0));
    check("por_out_valid", 32'(out_valid), 32'(0));
    check("por_out_last", 32'(out_last), 32'(0));
    check("por_out_data", 32'(out_data), 32'(0));
    check("por_state", 32'(dbg_state), 32'(0));
    rst_n = 1'b1;
    in_valid = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'(0));
    in_valid = 1'b0;

    // T2: full-rate streaming
    clear_stats();
    out_ready = 1'b1;
    pulse_start(1'b0);
    finish_frame(100, 100, 1'b0, 1'b0);
    check("t2_first_accept_after_start", 32'(first_acc_cyc - start_cyc), 32'(1));
    check("t2_accept_every_clk", 32'(last_acc_cyc - first_acc_cyc), 32'(TOTAL - 1));
    // accept edge to out_valid spans 4 edges, i.e. 5 falling-edge samples apart
    check("t2_first_out_valid_latency", 32'(first_ov_cyc - first_acc_cyc), 32'(LAT + 1));
    check_frame("t2");

    // T1: reset mid-RUN with 3 vectors in flight
    clear_stats();
    out_ready = 1'b1;
    pulse_start(1'b0);
    repeat (3) tick();
    check("t1_inflight_accepts", 32'(acc_total), 32'(3));
    rst_n = 1'b0;
    #1;
    check("t1_busy", 32'(busy), 32'(0));
    check("t1_in_ready", 32'(in_ready), 32'(0));
    check("t1_pp_valid", 32'(pp_features_valid), 32'(0));
    check("t1_out_valid", 32'(out_valid), 32'(0));
    check("t1_out_last", 32'(out_last), 32'(0));
    check("t1_out_data", 32'(out_data), 32'(0));
    check("t1_frame_done", 32'(frame_done), 32'(0));
    check("t1_state", 32'(dbg_state), 32'(0));
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("t1_out_valid_after_release", 32'(ov_seen), 32'(0));
    check("t1_state_after_release", 32'(dbg_state), 32'(0));
    check("t1_no_frame_done", 32'(done_cnt), 32'(0));

    // T3: back-pressure from the start
    clear_stats();
    out_ready = 1'b0;
    pulse_start(1'b0);
    for (int i = 0; i < 20; i++) begin
      drive_feat(1'b0);
      tick();
    end
    check("t3_accepts_to_full", 32'(acc_total), 32'(DEPTH));
    check("t3_in_ready_low", 32'(in_ready), 32'(0));
    check("t3_max_occupancy", 32'(max_occ), 32'(DEPTH));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_feat(1'b0);
      tick();
    end
    check("t3_one_more_accept", 32'(acc_total), 32'(DEPTH + 1));
    finish_frame(100, 100, 1'b0, 1'b0);
    check_frame("t3");

    // T4: all-ones vectors reduce to 2
    clear_stats();
    out_ready = 1'b1;
    pulse_start(1'b1);
    finish_frame(100, 100, 1'b1, 1'b0);
    check("t4_ones_data", 32'(first_data), 32'(2));
    check_frame("t4");

    // T5: start pulses during RUN and DRAIN are ignored
    clear_stats();
    pulse_start(1'b0);
    finish_frame(80, 40, 1'b0, 1'b1);
    check_frame("t5");

    // T6: gapped input and output
    clear_stats();
    pulse_start(1'b0);
    finish_frame(50, 30, 1'b0, 1'b0);
    check_frame("t6");

    check("fifo_never_overfilled", 32'(max_occ <= DEPTH), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
